// File: rtl/fifo_sync_ext.sv
// Synchronous FIFO for any DEPTH >= 2, with registered or first-word-fall-through read,
// programmable almost-full/almost-empty levels, flush, and sticky overflow/underflow flags.
module fifo_sync_ext #(
    parameter int DEPTH         = 12,
    parameter int DATA_WIDTH    = 8,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [DATA_WIDTH-1:0]          data_wr,
    input  logic                           wr_en,
    output logic                           fifo_full,
    output logic                           almost_full,
    output logic [DATA_WIDTH-1:0]          data_rd,
    input  logic                           rd_en,
    output logic                           rd_valid,
    output logic                           fifo_empty,
    output logic                           almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           overflow,
    output logic                           underflow,
    input  logic                           err_clr
);

    localparam int CW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [DATA_WIDTH-1:0] data_rd_q, data_rd_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic full_s, empty_s, wr_acc_s, rd_acc_s;

    // Pointers wrap explicitly since DEPTH need not be a power of two.
    function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] ptr);
        if (ptr == CW'(DEPTH - 1)) begin
            return {CW{1'b0}};
        end else begin
            return ptr + CW'(1);
        end
    endfunction

    // Flag decode and accept qualification from the registered level.
    always_comb begin
        full_s   = (level_q == LW'(DEPTH));
        empty_s  = (level_q == LW'(0));
        wr_acc_s = wr_en & ~full_s & ~flush;
        rd_acc_s = rd_en & ~empty_s & ~flush;
    end

    // Next-state for pointers, level, registered read path and sticky errors.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        data_rd_d   = data_rd_q;
        rd_valid_d  = 1'b0;
        if (flush) begin
            wr_ptr_d = {CW{1'b0}};
            rd_ptr_d = {CW{1'b0}};
            level_d  = LW'(0);
        end else begin
            if (wr_acc_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d   = ptr_inc(rd_ptr_q);
                data_rd_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end else begin
                rd_ptr_d   = rd_ptr_q;
                data_rd_d  = data_rd_q;
                rd_valid_d = 1'b0;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
        // A new error in the same cycle as err_clr keeps the flag set.
        overflow_d  = (wr_en & full_s & ~flush)  | (overflow_q  & ~err_clr);
        underflow_d = (rd_en & empty_s & ~flush) | (underflow_q & ~err_clr);
    end

    // Control and read-path state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= {CW{1'b0}};
            rd_ptr_q    <= {CW{1'b0}};
            level_q     <= LW'(0);
            data_rd_q   <= {DATA_WIDTH{1'b0}};
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            data_rd_q   <= data_rd_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array, deliberately left without reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_q[wr_ptr_q] <= data_wr;
        end
    end

    assign fifo_full    = full_s;
    assign fifo_empty   = empty_s;
    assign almost_full  = (level_q >= LW'(AFULL_THRESH));
    assign almost_empty = (level_q <= LW'(AEMPTY_THRESH));
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // FWFT shows the head directly; the empty mux keeps unwritten entries off the output.
    generate
        if (FWFT != 0) begin : g_fwft
            assign data_rd  = empty_s ? {DATA_WIDTH{1'b0}} : mem_q[rd_ptr_q];
            assign rd_valid = ~empty_s;
        end else begin : g_reg
            assign data_rd  = data_rd_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_ext.sv
// Directed bench for fifo_sync_ext: one registered-read instance and one FWFT instance.
module tb_fifo_sync_ext;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush, wr_en, rd_en, err_clr;
    logic [7:0] data_wr;
    logic       fifo_full, almost_full, rd_valid, fifo_empty, almost_empty, overflow, underflow;
    logic [7:0] data_rd;
    logic [3:0] level;

    logic       f_flush, f_wr_en, f_rd_en, f_err_clr;
    logic [7:0] f_data_wr;
    logic       f_full, f_afull, f_rd_valid, f_empty, f_aempty, f_ovf, f_udf;
    logic [7:0] f_data_rd;
    logic [3:0] f_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_sync_ext #(.DEPTH(12), .DATA_WIDTH(8), .FWFT(0), .AFULL_THRESH(10), .AEMPTY_THRESH(2)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .data_wr(data_wr), .wr_en(wr_en),
        .fifo_full(fifo_full), .almost_full(almost_full), .data_rd(data_rd), .rd_en(rd_en),
        .rd_valid(rd_valid), .fifo_empty(fifo_empty), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    fifo_sync_ext #(.DEPTH(12), .DATA_WIDTH(8), .FWFT(1), .AFULL_THRESH(10), .AEMPTY_THRESH(2)) u_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .data_wr(f_data_wr), .wr_en(f_wr_en),
        .fifo_full(f_full), .almost_full(f_afull), .data_rd(f_data_rd), .rd_en(f_rd_en),
        .rd_valid(f_rd_valid), .fifo_empty(f_empty), .almost_empty(f_aempty), .level(f_level),
        .overflow(f_ovf), .underflow(f_udf), .err_clr(f_err_clr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if ({fifo_full, almost_full, fifo_empty, almost_empty} !== 4'b0011) begin
            bad++; $display("FAIL %s_flags got=%b exp=0011", tag, {fifo_full, almost_full, fifo_empty, almost_empty});
        end
        total++;
        if (level !== 4'd0) begin bad++; $display("FAIL %s_level got=%0d exp=0", tag, level); end
        total++;
        if ({rd_valid, data_rd} !== 9'h000) begin
            bad++; $display("FAIL %s_rd got=%b/%h exp=0/00", tag, rd_valid, data_rd);
        end
        total++;
        if ({overflow, underflow} !== 2'b00) begin
            bad++; $display("FAIL %s_err got=%b exp=00", tag, {overflow, underflow});
        end
        total++;
        if ({f_rd_valid, f_data_rd, f_empty} !== 10'h001) begin
            bad++; $display("FAIL %s_fwft got=%b/%h/%b exp=0/00/1", tag, f_rd_valid, f_data_rd, f_empty);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; data_wr = 8'h00;
        f_flush = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_err_clr = 1'b0; f_data_wr = 8'h00;
        #2;
        check_reset_values("reset");
        step(); step();
        rst = 1'b0;
        step();
        check_reset_values("post_reset");
    endtask

    task automatic test_fwft();
        f_wr_en = 1'b1; f_data_wr = 8'hA5;
        step();
        total++;
        if ({f_rd_valid, f_data_rd} !== 9'h1A5) begin
            bad++; $display("FAIL fwft_first got=%b/%h exp=1/a5", f_rd_valid, f_data_rd);
        end
        f_data_wr = 8'h5A;
        step();
        total++;
        if ({f_data_rd, f_level} !== 12'hA52) begin
            bad++; $display("FAIL fwft_head got=%h/%0d exp=a5/2", f_data_rd, f_level);
        end
        f_wr_en = 1'b0; f_rd_en = 1'b1;
        step();
        total++;
        if ({f_rd_valid, f_data_rd} !== 9'h15A) begin
            bad++; $display("FAIL fwft_pop1 got=%b/%h exp=1/5a", f_rd_valid, f_data_rd);
        end
        step();
        f_rd_en = 1'b0;
        total++;
        if ({f_empty, f_rd_valid, f_data_rd} !== 10'h200) begin
            bad++; $display("FAIL fwft_pop2 got=%b/%b/%h exp=1/0/00", f_empty, f_rd_valid, f_data_rd);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 12; i++) begin
            wr_en = 1'b1; data_wr = 8'(i);
            step();
            total++;
            if (level !== 4'(i)) begin bad++; $display("FAIL fill_level got=%0d exp=%0d", level, i); end
            total++;
            if ({fifo_full, almost_full, fifo_empty, almost_empty} !== {i == 12, i >= 10, 1'b0, i <= 2}) begin
                bad++; $display("FAIL fill_flags at=%0d got=%b", i, {fifo_full, almost_full, fifo_empty, almost_empty});
            end
        end
        data_wr = 8'hFF;
        step();
        wr_en = 1'b0;
        total++;
        if ({overflow, fifo_full, level} !== {1'b1, 1'b1, 4'd12}) begin
            bad++; $display("FAIL overflow_write got=%b/%b/%0d exp=1/1/12", overflow, fifo_full, level);
        end
        for (int i = 1; i <= 12; i++) begin
            rd_en = 1'b1;
            step();
            total++;
            if ({rd_valid, data_rd, level} !== {1'b1, 8'(i), 4'(12 - i)}) begin
                bad++; $display("FAIL drain got=%b/%h/%0d exp=1/%h/%0d", rd_valid, data_rd, level, 8'(i), 12 - i);
            end
        end
        rd_en = 1'b0;
        step();
        total++;
        if ({rd_valid, data_rd, fifo_empty} !== {1'b0, 8'h0C, 1'b1}) begin
            bad++; $display("FAIL idle_hold got=%b/%h/%b exp=0/0c/1", rd_valid, data_rd, fifo_empty);
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        total++;
        if ({underflow, rd_valid, level} !== {1'b1, 1'b0, 4'd0}) begin
            bad++; $display("FAIL underflow_read got=%b/%b/%0d exp=1/0/0", underflow, rd_valid, level);
        end
    endtask

    task automatic test_err_clr();
        err_clr = 1'b1; rd_en = 1'b1;
        step();
        total++;
        if ({overflow, underflow} !== 2'b01) begin
            bad++; $display("FAIL errclr_set_wins got=%b exp=01", {overflow, underflow});
        end
        rd_en = 1'b0;
        step();
        err_clr = 1'b0;
        total++;
        if ({overflow, underflow} !== 2'b00) begin
            bad++; $display("FAIL errclr_clear got=%b exp=00", {overflow, underflow});
        end
    endtask

    task automatic test_collide();
        wr_en = 1'b1; rd_en = 1'b1; data_wr = 8'h55;
        step();
        rd_en = 1'b0;
        total++;
        if ({level, underflow, rd_valid} !== {4'd1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL empty_collide got=%0d/%b/%b exp=1/1/0", level, underflow, rd_valid);
        end
        for (int i = 0; i < 11; i++) begin
            data_wr = 8'h60 + 8'(i);
            step();
        end
        total++;
        if ({level, fifo_full} !== {4'd12, 1'b1}) begin
            bad++; $display("FAIL refill got=%0d/%b exp=12/1", level, fifo_full);
        end
        rd_en = 1'b1; data_wr = 8'hEE;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        total++;
        if ({level, overflow, rd_valid, data_rd} !== {4'd11, 1'b1, 1'b1, 8'h55}) begin
            bad++; $display("FAIL full_collide got=%0d/%b/%b/%h exp=11/1/1/55", level, overflow, rd_valid, data_rd);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if ({level, fifo_empty, overflow, underflow} !== {4'd0, 1'b1, 1'b1, 1'b1}) begin
            bad++; $display("FAIL flush_keeps_err got=%0d/%b/%b/%b exp=0/1/1/1", level, fifo_empty, overflow, underflow);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        total++;
        if ({overflow, underflow} !== 2'b00) begin
            bad++; $display("FAIL collide_clear got=%b exp=00", {overflow, underflow});
        end
    endtask

    task automatic test_wrap();
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_wr = 8'h10 + 8'(i);
            step();
        end
        rd_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] exp_d;
            exp_d   = (i < 5) ? (8'h10 + 8'(i)) : (8'h20 + 8'(i - 5));
            data_wr = 8'h20 + 8'(i);
            step();
            total++;
            if ({rd_valid, data_rd, level} !== {1'b1, exp_d, 4'd5}) begin
                bad++; $display("FAIL wrap i=%0d got=%b/%h/%0d exp=1/%h/5", i, rd_valid, data_rd, level, exp_d);
            end
        end
        wr_en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            total++;
            if ({data_rd, level} !== {8'h39 + 8'(j), 4'(4 - j)}) begin
                bad++; $display("FAIL wrap_drain got=%h/%0d exp=%h/%0d", data_rd, level, 8'h39 + 8'(j), 4 - j);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_flush();
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_wr = 8'h70 + 8'(i);
            step();
        end
        total++;
        if ({level, almost_full} !== {4'd8, 1'b0}) begin
            bad++; $display("FAIL flush_pre got=%0d/%b exp=8/0", level, almost_full);
        end
        flush = 1'b1; rd_en = 1'b1; data_wr = 8'h99;
        step();
        flush = 1'b0; rd_en = 1'b0;
        total++;
        if ({level, fifo_empty, rd_valid, data_rd} !== {4'd0, 1'b1, 1'b0, 8'h3D}) begin
            bad++; $display("FAIL flush got=%0d/%b/%b/%h exp=0/1/0/3d", level, fifo_empty, rd_valid, data_rd);
        end
        data_wr = 8'hAB;
        step();
        wr_en = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        total++;
        if ({rd_valid, data_rd, level} !== {1'b1, 8'hAB, 4'd0}) begin
            bad++; $display("FAIL post_flush got=%b/%h/%0d exp=1/ab/0", rd_valid, data_rd, level);
        end
    endtask

    task automatic test_reset_mid();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0; wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_wr = 8'hC0 + 8'(i);
            step();
        end
        rd_en = 1'b1; data_wr = 8'hC3;
        step();
        rd_en = 1'b0;
        total++;
        if ({underflow, rd_valid, data_rd, level} !== {1'b1, 1'b1, 8'hC0, 4'd3}) begin
            bad++; $display("FAIL pre_rst got=%b/%b/%h/%0d exp=1/1/c0/3", underflow, rd_valid, data_rd, level);
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("mid_reset");
        step();
        rst = 1'b0; wr_en = 1'b1; data_wr = 8'hD1;
        step();
        wr_en = 1'b0; rd_en = 1'b1;
        total++;
        if (level !== 4'd1) begin bad++; $display("FAIL after_rst_level got=%0d exp=1", level); end
        step();
        rd_en = 1'b0;
        total++;
        if ({rd_valid, data_rd, fifo_empty} !== {1'b1, 8'hD1, 1'b1}) begin
            bad++; $display("FAIL after_rst_read got=%b/%h/%b exp=1/d1/1", rd_valid, data_rd, fifo_empty);
        end
    endtask

    initial begin
        test_reset();
        test_fwft();
        test_fill_drain();
        test_err_clr();
        test_collide();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_sync_ext.md
FIFO_SYNC_EXT -- requirements
Module: fifo_sync_ext

Interface
REQ-001 Parameters SHALL be:
- DEPTH, 12: number of entries, any value >= 2, power of two not required.
- DATA_WIDTH, 8: bits per entry.
- FWFT, 0: 0 = registered read; 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-2: almost_full level.
- AEMPTY_THRESH, 2: almost_empty level.
REQ-002 Parameter legality SHALL be 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH; CW = clog2(DEPTH) is the pointer width and LW = clog2(DEPTH+1) is the level width.
REQ-003 Ports SHALL be:
- clk  in  1  single clock for all state.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of contents.
- data_wr  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- fifo_full  out  1  no free entry.
- almost_full  out  1  level >= AFULL_THRESH.
- data_rd  out  DATA_WIDTH  read data.
- rd_en  in  1  read request (pop).
- rd_valid  out  1  data_rd qualifier.
- fifo_empty  out  1  no stored entry.
- almost_empty  out  1  level <= AEMPTY_THRESH.
- level  out  LW  stored entry count, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- err_clr  in  1  clears overflow/underflow.

Function
REQ-004 Write pointer and read pointer SHALL each advance by one per accepted operation, wrapping from DEPTH-1 to 0.
REQ-005 A write SHALL be accepted iff wr_en=1, fifo_full=0 and flush=0; data_wr is stored at the write pointer on that edge.
REQ-006 A read SHALL be accepted iff rd_en=1, fifo_empty=0 and flush=0.
REQ-007 level SHALL be registered and change only as follows:
- +1 on write only.
- -1 on read only.
- unchanged on simultaneous accepted read and write.
REQ-008 The flags SHALL be decoded from the registered level:
- fifo_full = (level==DEPTH).
- fifo_empty = (level==0).
- almost_full = (level>=AFULL_THRESH).
- almost_empty = (level<=AEMPTY_THRESH).
REQ-009 When full, a write SHALL NOT be accepted even if a read is accepted in the same cycle; the read proceeds alone.
REQ-010 When empty, a read SHALL NOT be accepted even if a write is accepted in the same cycle; the write proceeds alone.
REQ-011 FWFT=0 read path:
- On an accepted read, data_rd SHALL load the head entry at the next edge and rd_valid SHALL be 1 for exactly that following cycle.
- Otherwise rd_valid SHALL be 0 and data_rd SHALL hold its last value.
REQ-012 FWFT=1 read path:
- data_rd SHALL present the head entry whenever fifo_empty=0, with rd_valid = !fifo_empty; rd_en pops the entry.
- data_rd SHALL be all-zero when empty.
REQ-013 In FWFT=1 mode, a word written into an empty FIFO SHALL appear on data_rd with rd_valid=1 one cycle after the write edge.
REQ-014 Flush SHALL override all simultaneous wr_en/rd_en:
- flush=1 sets both pointers and level to 0 at the next edge and accepts no operation that cycle.
- In FWFT=0 mode, flush SHALL also clear rd_valid; data_rd holds.
REQ-015 overflow SHALL set on any edge with wr_en=1, fifo_full=1 and flush=0.
REQ-016 underflow SHALL set on any edge with rd_en=1, fifo_empty=1 and flush=0.
REQ-017 overflow and underflow SHALL remain set until an edge with err_clr=1; a set condition in the same cycle as err_clr wins; flush SHALL NOT clear them.
REQ-018 Rejected operations SHALL NOT modify storage, pointers or level.
REQ-019 Storage contents SHALL NOT require reset; no output may depend on an unwritten entry.

Reset
REQ-020 rst=1 SHALL asynchronously force:
- pointers=0, level=0.
- fifo_empty=1, almost_empty=1, fifo_full=0.
- almost_full=0 (AFULL_THRESH>0).
- rd_valid=0, data_rd=0.
- overflow=0, underflow=0.
REQ-021 Reset asserted mid-operation SHALL discard all contents; the first edge after deassertion behaves as from empty.

Verification
REQ-022 DEPTH=12, FWFT=0: write 12 words 0x01..0x0C -> fifo_full=1 and level=12; a 13th write sets overflow, level stays 12; 12 reads return 0x01..0x0C in order, each with rd_valid one cycle after the read accept.
REQ-023 DEPTH=12, partly filled at level 5: 30 cycles of simultaneous wr_en/rd_en -> level stays 5, pointers wrap past 11 to 0, data order preserved.
REQ-024 Full FIFO with wr_en=rd_en=1 -> only the read is accepted, level goes 12->11, overflow sets; empty FIFO with wr_en=rd_en=1 -> level goes 0->1, underflow sets.
REQ-025 FWFT=1: write 0xA5 into empty FIFO -> next cycle data_rd=0xA5, rd_valid=1; rd_en=1 pops it -> fifo_empty=1, data_rd=0.
REQ-026 Threshold and error checks:
- Level 8 with flush=1, wr_en=1 -> level=0, fifo_empty=1, no write stored.
- AFULL_THRESH=10 -> almost_full rises exactly at level 10.
- err_clr=1 with overflow set -> overflow=0 next cycle.
- rst pulse mid-burst -> all REQ-020 values immediately.
